lstm_seq_ctrl: RTL and testbench
================================

# lstm_seq_ctrl

Sequencing and state-holding stage directly upstream of the LSTM cell array. It accepts one input vector per timestep, assembles each cell's concatenated input {h(t-1), x(t)} and previous cell state c(t-1), and waits for the cells' results. It then registers the new c(t)/h(t) for the next step and records them in a per-timestep history memory for backpropagation through time.

## Interface
- WIDTH, 32, word width (Q7.24 fixed point, FRAC = 24)
- NUM, 68, input-layer words per timestep
- NUM_LSTM, 8, number of LSTM cells
- DEPTH, 32, history depth in timesteps (≤ 256)
- clk  in  1  clock; all logic is rising-edge
- rst  in  1  asynchronous, active-high reset
- i_start  in  1  begin a new sequence
- i_x_valid  in  1  i_x holds a valid input vector
- i_x  in  NUM*WIDTH  input vector x(t)
- o_x_ready  out  1  block accepts i_x this cycle
- o_k  out  (NUM+NUM_LSTM)*WIDTH  cell input: words [NUM-1:0] = x(t), words [NUM+NUM_LSTM-1:NUM] = h(t-1), with cell j at word NUM+j
- o_prev_state  out  NUM_LSTM*WIDTH  c(t-1), with cell j at word j
- o_k_valid  out  1  o_k and o_prev_state are valid and the cells are evaluating
- i_res_valid  in  1  cell results are valid
- i_c, i_h  in  NUM_LSTM*WIDTH each  c(t) and h(t) from the cells, with cell j at word j
- o_t  out  9  current timestep index (unsigned, zero-extended to match the cells' 9-bit addresses)
- o_full  out  1  history holds DEPTH timesteps
- i_hist_addr  in  9  history read address
- o_hist_c, o_hist_h  out  NUM_LSTM*WIDTH each  stored c and h at i_hist_addr

## Operation
- FSM states: IDLE, LOAD, BUSY.
- i_start, in any state, has top priority:
  - next state is LOAD;
  - the h and c registers clear to 0;
  - o_t clears to 0 and o_full clears to 0;
  - history contents are retained.
- IDLE:
  - o_x_ready = 0 and o_k_valid = 0;
  - i_x_valid and i_res_valid are ignored.
- LOAD:
  - o_x_ready = 1;
  - when i_x_valid = 1, latch i_x into the x field of o_k and go to BUSY.
- BUSY:
  - o_k_valid = 1 and o_x_ready = 0;
  - o_k and o_prev_state are held stable;
  - i_x_valid is ignored.
- BUSY with i_res_valid = 1:
  - h ← i_h and c ← i_c;
  - history[o_t] ← {i_c, i_h};
  - if o_t == DEPTH-1: set o_full = 1, hold o_t, go to IDLE;
  - otherwise: o_t ← o_t+1, go to LOAD.
- i_res_valid outside BUSY is ignored and has no state change.
- The h field of o_k and o_prev_state always reflect the h and c registers.
- The x field is 0 after reset and is updated only on acceptance.
- No arithmetic is performed on data. Values pass through bit-exact.
- History read:
  - synchronous, with registered outputs;
  - i_hist_addr ≥ DEPTH returns all zeros;
  - a same-cycle write and read to the same address returns the old data (read-before-write).
- rst during any state forces the reset values immediately; an in-flight step is abandoned.

## Timing
- Reset values:
  - FSM state IDLE;
  - o_x_ready = 0, o_k_valid = 0, o_full = 0, o_t = 0;
  - o_k, o_prev_state, o_hist_c and o_hist_h all zero;
  - history contents are undefined.
- i_start at cycle N → o_x_ready = 1 at N+1.
- i_x_valid and o_x_ready both high at cycle N → o_k_valid = 1 and the new x visible on o_k at N+1.
- i_res_valid at cycle M in BUSY → at M+1:
  - o_k_valid = 0;
  - o_x_ready = 1, unless the sequence is full;
  - o_k/o_prev_state show the new h/c;
  - o_t has incremented.
- Minimum step period is 2 cycles (accept, then result); steady-state throughput is one timestep per cell latency plus 1.
- i_start in the same cycle as i_res_valid: i_start wins; no history write and no register update occur.
- History read latency is 1 cycle from i_hist_addr to o_hist_c/o_hist_h.

## Test plan
- Reset, then i_start, then x = all words 0x01000000; cells return c = 0x00800000 and h = 0x00400000 on every word, 3 cycles after o_k_valid. Required:
  - o_k_valid is high for exactly 3 cycles;
  - o_t goes 0→1;
  - o_k words NUM..NUM+7 = 0x00400000 and o_prev_state words = 0x00800000.
- With DEPTH = 4, run 4 steps where step t returns h = t+1 and c = 0x10+t. Required:
  - after the 4th result, o_full = 1, state IDLE, o_t = 3 and o_x_ready = 0;
  - reading addresses 0..3 returns h = 1..4 and c = 0x10..0x13;
  - reading address 4 returns 0.
- i_x_valid pulsed during BUSY with a different vector → o_k x field unchanged; i_res_valid pulsed in LOAD → o_t unchanged and h/c unchanged.
- i_start asserted in the same cycle as i_res_valid at o_t = 2. Required:
  - o_t = 0 and h = c = 0 at the next cycle;
  - history[2] still holds its prior contents.
- rst asserted asynchronously mid-BUSY (between clock edges) → o_k_valid and all outputs go to 0 before the next clock edge; after release, the block stays IDLE until i_start.
- Read and write history[1] in the same cycle → o_hist returns the old value; reading again the next cycle returns the new value.

Source files
------------

// File: rtl/lstm_seq_ctrl.sv
// Timestep sequencer in front of the LSTM cell array: assembles {h(t-1), x(t)} and c(t-1),
// waits for the cell results, and records every step's c/h in a history RAM.
module lstm_seq_ctrl #(
   parameter int WIDTH    = 32,
   parameter int NUM      = 68,
   parameter int NUM_LSTM = 8,
   parameter int DEPTH    = 32
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             i_start,
   input  logic                             i_x_valid,
   input  logic [NUM*WIDTH-1:0]             i_x,
   output logic                             o_x_ready,
   output logic [(NUM+NUM_LSTM)*WIDTH-1:0]  o_k,
   output logic [NUM_LSTM*WIDTH-1:0]        o_prev_state,
   output logic                             o_k_valid,
   input  logic                             i_res_valid,
   input  logic [NUM_LSTM*WIDTH-1:0]        i_c,
   input  logic [NUM_LSTM*WIDTH-1:0]        i_h,
   output logic [8:0]                       o_t,
   output logic                             o_full,
   input  logic [8:0]                       i_hist_addr,
   output logic [NUM_LSTM*WIDTH-1:0]        o_hist_c,
   output logic [NUM_LSTM*WIDTH-1:0]        o_hist_h
);

   localparam int         VW     = NUM_LSTM * WIDTH;
   localparam int         AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [8:0] T_LAST = 9'(DEPTH - 1);
   localparam logic [8:0] T_END  = 9'(DEPTH);

   typedef enum logic [1:0] {IDLE, LOAD, BUSY} state_t;

   state_t               state_reg, state_next;
   logic [NUM*WIDTH-1:0] x_reg;
   logic [VW-1:0]        h_reg, c_reg;
   logic [8:0]           t_reg;
   logic                 full_reg;
   logic                 accept, commit;
   logic [2*VW-1:0]      hist_mem [DEPTH];
   logic [VW-1:0]        hist_c_reg, hist_h_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_reg <= IDLE;
      else     state_reg <= state_next;
   end

   // i_start overrides everything, including a result arriving in the same cycle
   always_comb begin
      state_next = state_reg;
      o_x_ready  = 1'b0;
      o_k_valid  = 1'b0;
      accept     = 1'b0;
      commit     = 1'b0;
      case (state_reg)
         LOAD:    o_x_ready = 1'b1;
         BUSY:    o_k_valid = 1'b1;
         default: ;
      endcase
      if (i_start) begin
         state_next = LOAD;
      end else begin
         case (state_reg)
            LOAD: begin
               if (i_x_valid) begin
                  accept     = 1'b1;
                  state_next = BUSY;
               end
            end
            BUSY: begin
               if (i_res_valid) begin
                  commit     = 1'b1;
                  state_next = (t_reg == T_LAST) ? IDLE : LOAD;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x_reg    <= '0;
         h_reg    <= '0;
         c_reg    <= '0;
         t_reg    <= '0;
         full_reg <= 1'b0;
      end else if (i_start) begin
         h_reg    <= '0;
         c_reg    <= '0;
         t_reg    <= '0;
         full_reg <= 1'b0;
      end else if (accept) begin
         x_reg <= i_x;
      end else if (commit) begin
         h_reg <= i_h;
         c_reg <= i_c;
         if (t_reg == T_LAST) full_reg <= 1'b1;
         else                 t_reg    <= t_reg + 9'd1;
      end
   end

   // History RAM: contents survive reset and i_start; the read port sees pre-write data
   always_ff @(posedge clk) begin
      if (commit) hist_mem[t_reg[AW-1:0]] <= {i_c, i_h};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hist_c_reg <= '0;
         hist_h_reg <= '0;
      end else if (i_hist_addr < T_END) begin
         {hist_c_reg, hist_h_reg} <= hist_mem[i_hist_addr[AW-1:0]];
      end else begin
         hist_c_reg <= '0;
         hist_h_reg <= '0;
      end
   end

   assign o_k          = {h_reg, x_reg};
   assign o_prev_state = c_reg;
   assign o_t          = t_reg;
   assign o_full       = full_reg;
   assign o_hist_c     = hist_c_reg;
   assign o_hist_h     = hist_h_reg;

endmodule

// File: tb/tb_lstm_seq_ctrl.sv
// Scoreboard bench for lstm_seq_ctrl with a 4-deep history; expected step results and
// history reads are queued when driven and compared when the DUT presents them.
module tb_lstm_seq_ctrl;

   localparam int W  = 32;
   localparam int N  = 68;
   localparam int L  = 8;
   localparam int D  = 4;
   localparam int VW = L * W;

   logic                 clk = 1'b0;
   logic                 rst, i_start, i_x_valid, i_res_valid;
   logic [N*W-1:0]       i_x;
   logic                 o_x_ready, o_k_valid, o_full;
   logic [(N+L)*W-1:0]   o_k;
   logic [VW-1:0]        o_prev_state, i_c, i_h, o_hist_c, o_hist_h;
   logic [8:0]           o_t, i_hist_addr;

   always #5 clk = ~clk;

   lstm_seq_ctrl #(.WIDTH(W), .NUM(N), .NUM_LSTM(L), .DEPTH(D)) dut (
      .clk(clk), .rst(rst), .i_start(i_start), .i_x_valid(i_x_valid), .i_x(i_x),
      .o_x_ready(o_x_ready), .o_k(o_k), .o_prev_state(o_prev_state), .o_k_valid(o_k_valid),
      .i_res_valid(i_res_valid), .i_c(i_c), .i_h(i_h), .o_t(o_t), .o_full(o_full),
      .i_hist_addr(i_hist_addr), .o_hist_c(o_hist_c), .o_hist_h(o_hist_h)
   );

   typedef struct {
      logic [8:0]    t;
      logic [VW-1:0] h;
      logic [VW-1:0] c;
      logic          rdy;
      logic          full;
   } step_exp_t;

   typedef struct {
      logic [VW-1:0] h;
      logic [VW-1:0] c;
   } hist_exp_t;

   step_exp_t step_q[$];
   hist_exp_t hist_q[$];

   int          test_cnt = 0;
   int          fail_cnt = 0;
   logic [8:0]  m_t;
   logic        m_full;
   logic [31:0] m_hh [D];
   logic [31:0] m_hc [D];

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      test_cnt++;
      if (got !== exp) begin
         fail_cnt++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [N*W-1:0] xvec(input logic [31:0] base, input logic [31:0] inc);
      logic [N*W-1:0] r;
      for (int w = 0; w < N; w++) r[w*W +: W] = base + inc * 32'(w);
      return r;
   endfunction

   task automatic start_seq;
      i_start = 1'b1;
      tick;
      i_start = 1'b0;
      m_t = '0;
      m_full = 1'b0;
      check("start_rdy", o_x_ready, 1);
      check("start_t", o_t, 0);
      check("start_h", o_k[N*W +: VW], 0);
      check("start_c", o_prev_state, 0);
      $display("[TB] start sequence");
   endtask

   task automatic accept(input logic [N*W-1:0] x);
      i_x = x;
      i_x_valid = 1'b1;
      tick;
      i_x_valid = 1'b0;
      check("acc_kvalid", o_k_valid, 1);
      check("acc_rdy", o_x_ready, 0);
      check("acc_x0", o_k[31:0], x[31:0]);
      check("acc_xlast", o_k[(N-1)*W +: W], x[(N-1)*W +: W]);
   endtask

   task automatic result(input int lat, input logic [31:0] h, input logic [31:0] c);
      int        cnt;
      step_exp_t e;
      cnt = 1;
      for (int k = 1; k < lat; k++) begin
         tick;
         if (o_k_valid) cnt++;
      end
      i_h = {L{h}};
      i_c = {L{c}};
      i_res_valid = 1'b1;
      m_hh[m_t[1:0]] = h;
      m_hc[m_t[1:0]] = c;
      if (m_t == 9'(D - 1)) m_full = 1'b1;
      else                  m_t = m_t + 9'd1;
      e.t = m_t; e.h = {L{h}}; e.c = {L{c}}; e.rdy = !m_full; e.full = m_full;
      step_q.push_back(e);
      tick;
      i_res_valid = 1'b0;
      e = step_q.pop_front();
      check("busy_cycles", cnt, lat);
      check("res_kvalid", o_k_valid, 0);
      check("res_t", o_t, e.t);
      check("res_h", o_k[N*W +: VW], e.h);
      check("res_c", o_prev_state, e.c);
      check("res_rdy", o_x_ready, e.rdy);
      check("res_full", o_full, e.full);
      $display("[TB] step result h=%h c=%h -> t=%0d full=%0d", h, c, o_t, o_full);
   endtask

   task automatic push_hist(input logic [8:0] a);
      hist_exp_t e;
      if (a < 9'(D)) begin
         e.h = {L{m_hh[a[1:0]]}};
         e.c = {L{m_hc[a[1:0]]}};
      end else begin
         e.h = '0;
         e.c = '0;
      end
      hist_q.push_back(e);
   endtask

   task automatic pop_hist(input string tag);
      hist_exp_t e;
      e = hist_q.pop_front();
      check({tag, "_h"}, o_hist_h, e.h);
      check({tag, "_c"}, o_hist_c, e.c);
      $display("[TB] history read %s h=%h", tag, o_hist_h[31:0]);
   endtask

   task automatic rd(input logic [8:0] a);
      i_hist_addr = a;
      push_hist(a);
      tick;
      pop_hist($sformatf("hist%0d", a));
   endtask

   initial begin
      rst = 1'b1; i_start = 1'b0; i_x_valid = 1'b0; i_res_valid = 1'b0;
      i_x = '0; i_c = '0; i_h = '0; i_hist_addr = '0;
      m_t = '0; m_full = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_rdy", o_x_ready, 0);
      check("rst_kvalid", o_k_valid, 0);
      check("rst_full", o_full, 0);
      check("rst_t", o_t, 0);
      check("rst_k0", o_k[255:0], 0);
      check("rst_kh", o_k[N*W +: VW], 0);
      check("rst_prev", o_prev_state, 0);
      check("rst_hist", o_hist_h, 0);
      rst = 1'b0;
      tick;
      check("idle_rdy", o_x_ready, 0);

      // single step with 3-cycle cell latency
      start_seq;
      accept(xvec(32'h01000000, 0));
      result(3, 32'h00400000, 32'h00800000);

      // fill the 4-deep history
      start_seq;
      for (int t = 0; t < D; t++) begin
         accept(xvec(32'h100 * 32'(t), 1));
         result((t % 3) + 1, 32'(t + 1), 32'h10 + 32'(t));
      end
      check("full_t", o_t, 3);
      check("full_flag", o_full, 1);
      i_res_valid = 1'b1; i_h = '1; i_c = '1; i_x_valid = 1'b1;
      tick;
      i_res_valid = 1'b0; i_x_valid = 1'b0;
      check("idle_res_t", o_t, 3);
      check("idle_res_h", o_k[N*W +: VW], {L{32'd4}});
      check("idle_kvalid", o_k_valid, 0);
      check("idle_full", o_full, 1);
      for (int a = 0; a <= D; a++) rd(9'(a));

      // ignored inputs: result in LOAD, new x in BUSY
      start_seq;
      i_res_valid = 1'b1; i_h = '1; i_c = '1;
      tick;
      i_res_valid = 1'b0;
      check("load_res_t", o_t, 0);
      check("load_res_h", o_k[N*W +: VW], 0);
      check("load_res_c", o_prev_state, 0);
      check("load_res_rdy", o_x_ready, 1);
      accept(xvec(32'hAAAA0000, 1));
      i_x = xvec(32'h55550000, 1);
      i_x_valid = 1'b1;
      tick;
      i_x_valid = 1'b0;
      check("busy_x0", o_k[31:0], 32'hAAAA0000);
      check("busy_kvalid", o_k_valid, 1);
      result(2, 32'hA0, 32'hB0);
      accept(xvec(32'h3000, 2));
      result(2, 32'hA1, 32'hB1);

      // i_start collides with a result at t=2
      accept(xvec(32'h4000, 3));
      i_res_valid = 1'b1; i_start = 1'b1; i_h = {L{32'hEE}}; i_c = {L{32'hFF}};
      tick;
      i_res_valid = 1'b0; i_start = 1'b0;
      m_t = '0; m_full = 1'b0;
      check("coll_t", o_t, 0);
      check("coll_h", o_k[N*W +: VW], 0);
      check("coll_c", o_prev_state, 0);
      check("coll_rdy", o_x_ready, 1);
      check("coll_kvalid", o_k_valid, 0);
      rd(9'd2);

      // read-before-write on history[1]
      accept(xvec(32'h5000, 1));
      result(1, 32'hC0, 32'hD0);
      accept(xvec(32'h6000, 1));
      i_hist_addr = 9'd1;
      push_hist(9'd1);
      result(1, 32'hC1, 32'hD1);
      pop_hist("rbw_old");
      rd(9'd1);

      // asynchronous reset in the middle of BUSY
      accept(xvec(32'h7000, 1));
      #3 rst = 1'b1;
      #1;
      check("arst_kvalid", o_k_valid, 0);
      check("arst_rdy", o_x_ready, 0);
      check("arst_t", o_t, 0);
      check("arst_x0", o_k[31:0], 0);
      check("arst_prev", o_prev_state, 0);
      check("arst_hist", o_hist_h, 0);
      #1 rst = 1'b0;
      m_t = '0; m_full = 1'b0;
      i_x_valid = 1'b1;
      tick;
      tick;
      i_x_valid = 1'b0;
      check("post_rst_rdy", o_x_ready, 0);
      check("post_rst_kvalid", o_k_valid, 0);
      start_seq;

      $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
      $finish;
   end

endmodule
